// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issue controller for an iterative unsigned divider
// Queues operand pairs, issues one division at a time, returns tagged results in order.
module div_issue_ctrl #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_left,
  input  logic [W-1:0]     in_right,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_go,
  output logic [W-1:0]     div_left,
  output logic [W-1:0]     div_right,
  input  logic             div_done,
  input  logic [W-1:0]     div_quotient,
  input  logic [W-1:0]     div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_quotient,
  output logic [W-1:0]     out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_divzero,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [W-1:0]     r_fifo_left  [DEPTH];
  logic [W-1:0]     r_fifo_right [DEPTH];
  logic [TAG_W-1:0] r_fifo_tag   [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic [1:0]       r_state;
  logic [W-1:0]     r_op_left;
  logic [W-1:0]     r_op_right;
  logic [TAG_W-1:0] r_op_tag;
  logic [W-1:0]     r_res_q;
  logic [W-1:0]     r_res_r;
  logic             r_res_dz;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [W-1:0]     w_head_left;
  logic [W-1:0]     w_head_right;
  logic [TAG_W-1:0] w_head_tag;

  assign w_full       = (r_count == FULL_CNT);
  assign w_push       = in_valid && !w_full;
  assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
  assign w_head_left  = r_fifo_left[r_rd_ptr];
  assign w_head_right = r_fifo_right[r_rd_ptr];
  assign w_head_tag   = r_fifo_tag[r_rd_ptr];

  // Storage needs no reset: only entries below r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_left[r_wr_ptr]  <= in_left;
      r_fifo_right[r_wr_ptr] <= in_right;
      r_fifo_tag[r_wr_ptr]   <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE_PTR;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE_PTR;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op_left  <= '0;
      r_op_right <= '0;
      r_op_tag   <= '0;
      r_res_q    <= '0;
      r_res_r    <= '0;
      r_res_dz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op_left  <= w_head_left;
            r_op_right <= w_head_right;
            r_op_tag   <= w_head_tag;
            // A zero divisor never reaches the divider; its result is synthesised here.
            if (w_head_right == '0) begin
              r_res_q  <= '1;
              r_res_r  <= w_head_left;
              r_res_dz <= 1'b1;
              r_state  <= S_HOLD;
            end else begin
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (div_done) begin
            r_res_q  <= div_quotient;
            r_res_r  <= div_remainder;
            r_res_dz <= 1'b0;
            r_state  <= S_HOLD;
          end
        end
        default: begin
          if (out_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = !w_full;
  assign div_go        = (r_state == S_ISSUE);
  assign div_left      = r_op_left;
  assign div_right     = r_op_right;
  assign out_valid     = (r_state == S_HOLD);
  assign out_quotient  = r_res_q;
  assign out_remainder = r_res_r;
  assign out_tag       = r_op_tag;
  assign out_divzero   = r_res_dz;
  assign busy          = (r_state != S_IDLE) || (r_count != '0);

endmodule
